// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction-fetch / load-store memory arbiter.
package mem_arb_pkg;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RSP = 2'd1,
    LS_RSP = 2'd2
  } state_e;

  // Size encoding 3 has no legal meaning and is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Right-justifies the addressed byte/half/word of a RAM word and sign- or zero-extends it.
module mem_load_align
  import mem_arb_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {offset_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_o = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared RAM between instruction fetch and the LSU; LSU has priority
// until fetch has been passed over STARVE_LIMIT times in a row.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 31,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH:0]   i_if_addr,
  output logic                  o_if_ready,
  output logic                  o_if_valid,
  output logic [31:0]           o_if_data,
  input  logic                  i_ls_req,
  input  logic                  i_ls_we,
  input  logic [1:0]            i_ls_size,
  input  logic                  i_ls_unsigned,
  input  logic [ADDR_WIDTH:0]   i_ls_addr,
  input  logic [31:0]           i_ls_wdata,
  output logic                  o_ls_ready,
  output logic                  o_ls_valid,
  output logic [31:0]           o_ls_rdata,
  output logic                  o_ls_err,
  output logic                  o_ram_read_req,
  output logic [ADDR_WIDTH:0]   o_ram_read_addr,
  input  logic [31:0]           i_ram_read_data,
  output logic                  o_ram_write_enable,
  output logic [3:0]            o_ram_byte_enable,
  output logic [ADDR_WIDTH:0]   o_ram_write_addr,
  output logic [31:0]           o_ram_write_data,
  output logic [ADDR_WIDTH:0]   o_ram_fetch_addr,
  input  logic [31:0]           i_ram_fetch_data
);

  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic [31:0]     if_data_q;
  logic [31:0]     ls_word_q;
  logic [1:0]      ls_off_q;
  logic [1:0]      ls_size_q;
  logic            ls_uns_q;
  logic            ls_err_q;
  logic            ls_load_q;

  logic            adv, ls_gnt, if_gnt, ls_mis;
  logic [3:0]      be_base;
  logic [31:0]     ls_aligned;
  logic            unused_if_lsbs;

  assign unused_if_lsbs = ^i_if_addr[1:0];

  always_comb begin
    // NOTE: every combinational output is given a default first so no path can infer a latch.
    state_d  = state_q;
    starve_d = starve_q;
    adv      = clk_en & rst;
    ls_mis   = is_misaligned(i_ls_size, i_ls_addr[1:0]);
    ls_gnt   = adv & i_ls_req & ~(i_if_req & (starve_q == LIMIT));
    if_gnt   = adv & i_if_req & ~ls_gnt;
    if (adv) begin
      if (if_gnt)      state_d = IF_RSP;
      else if (ls_gnt) state_d = LS_RSP;
      else             state_d = IDLE;
      if (!i_if_req || if_gnt)               starve_d = '0;
      else if (ls_gnt && starve_q != LIMIT)  starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    be_base          = 4'b1111;
    o_ram_write_data = i_ls_wdata;
    case (i_ls_size)
      SZ_BYTE: begin
        be_base          = 4'b0001;
        o_ram_write_data = {4{i_ls_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_base          = 4'b0011;
        o_ram_write_data = {2{i_ls_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign o_if_ready         = if_gnt;
  assign o_ls_ready         = ls_gnt;
  assign o_ram_write_enable = ls_gnt & i_ls_we & ~ls_mis;
  assign o_ram_read_req     = ls_gnt & ~i_ls_we & ~ls_mis;
  assign o_ram_byte_enable  = o_ram_write_enable ? (be_base << i_ls_addr[1:0]) : 4'b0000;
  assign o_ram_write_addr   = {2'b00, i_ls_addr[ADDR_WIDTH:2]};
  assign o_ram_read_addr    = {2'b00, i_ls_addr[ADDR_WIDTH:2]};
  assign o_ram_fetch_addr   = {2'b00, i_if_addr[ADDR_WIDTH:2]};

  // NOTE: state and capture registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: data captures are reset too, since the response data outputs must read 0 out of reset.
      state_q   <= IDLE;
      starve_q  <= '0;
      if_data_q <= '0;
      ls_word_q <= '0;
      ls_off_q  <= '0;
      ls_size_q <= '0;
      ls_uns_q  <= 1'b0;
      ls_err_q  <= 1'b0;
      ls_load_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (if_gnt) if_data_q <= i_ram_fetch_data;
      if (ls_gnt) begin
        ls_word_q <= i_ram_read_data;
        ls_off_q  <= i_ls_addr[1:0];
        ls_size_q <= i_ls_size;
        ls_uns_q  <= i_ls_unsigned;
        ls_err_q  <= ls_mis;
        ls_load_q <= ~i_ls_we & ~ls_mis;
      end
    end
  end

  mem_load_align u_align (
    .word_i     (ls_word_q),
    .offset_i   (ls_off_q),
    .size_i     (ls_size_q),
    .unsigned_i (ls_uns_q),
    .data_o     (ls_aligned)
  );

  assign o_if_valid = (state_q == IF_RSP);
  assign o_if_data  = if_data_q;
  assign o_ls_valid = (state_q == LS_RSP);
  assign o_ls_err   = o_ls_valid & ls_err_q;
  assign o_ls_rdata = (o_ls_valid & ls_load_q) ? ls_aligned : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stores, loads, alignment errors, starvation, reset and clk_en.
module tb_mem_arbiter;

  localparam int AW = 31;

  logic          clk, rst, clk_en;
  logic          i_if_req;
  logic [AW:0]   i_if_addr;
  logic          o_if_ready, o_if_valid;
  logic [31:0]   o_if_data;
  logic          i_ls_req, i_ls_we, i_ls_unsigned;
  logic [1:0]    i_ls_size;
  logic [AW:0]   i_ls_addr;
  logic [31:0]   i_ls_wdata;
  logic          o_ls_ready, o_ls_valid, o_ls_err;
  logic [31:0]   o_ls_rdata;
  logic          o_ram_read_req, o_ram_write_enable;
  logic [AW:0]   o_ram_read_addr, o_ram_write_addr, o_ram_fetch_addr;
  logic [31:0]   i_ram_read_data, o_ram_write_data, i_ram_fetch_data;
  logic [3:0]    o_ram_byte_enable;

  int checks;
  int failures;

  mem_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .clk_en             (clk_en),
    .i_if_req           (i_if_req),
    .i_if_addr          (i_if_addr),
    .o_if_ready         (o_if_ready),
    .o_if_valid         (o_if_valid),
    .o_if_data          (o_if_data),
    .i_ls_req           (i_ls_req),
    .i_ls_we            (i_ls_we),
    .i_ls_size          (i_ls_size),
    .i_ls_unsigned      (i_ls_unsigned),
    .i_ls_addr          (i_ls_addr),
    .i_ls_wdata         (i_ls_wdata),
    .o_ls_ready         (o_ls_ready),
    .o_ls_valid         (o_ls_valid),
    .o_ls_rdata         (o_ls_rdata),
    .o_ls_err           (o_ls_err),
    .o_ram_read_req     (o_ram_read_req),
    .o_ram_read_addr    (o_ram_read_addr),
    .i_ram_read_data    (i_ram_read_data),
    .o_ram_write_enable (o_ram_write_enable),
    .o_ram_byte_enable  (o_ram_byte_enable),
    .o_ram_write_addr   (o_ram_write_addr),
    .o_ram_write_data   (o_ram_write_data),
    .o_ram_fetch_addr   (o_ram_fetch_addr),
    .i_ram_fetch_data   (i_ram_fetch_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ls_drive(input logic req, input logic we, input logic [1:0] size,
                          input logic uns, input logic [AW:0] addr, input logic [31:0] wdata);
    i_ls_req = req; i_ls_we = we; i_ls_size = size;
    i_ls_unsigned = uns; i_ls_addr = addr; i_ls_wdata = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b0; clk_en = 1'b1;
    ls_drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (o_ls_ready !== 1'b0) begin failures++; $display("FAIL rst_ls_ready got=%h exp=0", o_ls_ready); end
    checks++; if (o_ram_read_req !== 1'b0) begin failures++; $display("FAIL rst_read_req got=%h exp=0", o_ram_read_req); end
    checks++; if ({o_ls_valid, o_if_valid, o_ls_err} !== 3'b000) begin failures++; $display("FAIL rst_valids got=%b exp=000", {o_ls_valid, o_if_valid, o_ls_err}); end
    checks++; if ({o_ls_rdata, o_if_data} !== 64'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {o_ls_rdata, o_if_data}); end
    i_ls_req = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    step();
    checks++; if (o_ls_valid !== 1'b0) begin failures++; $display("FAIL rst_release_valid got=%h exp=0", o_ls_valid); end
  endtask

  task automatic test_store_load_word();
    ls_drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    checks++; if (o_ls_ready !== 1'b1) begin failures++; $display("FAIL sw_ready got=%h exp=1", o_ls_ready); end
    checks++; if (o_ram_write_enable !== 1'b1 || o_ram_read_req !== 1'b0) begin failures++; $display("FAIL sw_enables got=%b%b exp=10", o_ram_write_enable, o_ram_read_req); end
    checks++; if (o_ram_byte_enable !== 4'b1111) begin failures++; $display("FAIL sw_be got=%b exp=1111", o_ram_byte_enable); end
    checks++; if (o_ram_write_addr !== 32'h40) begin failures++; $display("FAIL sw_addr got=%h exp=40", o_ram_write_addr); end
    checks++; if (o_ram_write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_data got=%h exp=deadbeef", o_ram_write_data); end
    step();
    checks++; if (o_ls_valid !== 1'b1 || o_ls_rdata !== 32'h0 || o_ls_err !== 1'b0) begin failures++; $display("FAIL sw_rsp got=%b/%h/%b exp=1/0/0", o_ls_valid, o_ls_rdata, o_ls_err); end
    ls_drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    i_ram_read_data = 32'hDEADBEEF;
    #1;
    checks++; if (o_ram_read_req !== 1'b1 || o_ram_write_enable !== 1'b0) begin failures++; $display("FAIL lw_enables got=%b%b exp=10", o_ram_read_req, o_ram_write_enable); end
    checks++; if (o_ram_read_addr !== 32'h40) begin failures++; $display("FAIL lw_addr got=%h exp=40", o_ram_read_addr); end
    step();
    i_ls_req = 1'b0;
    i_ram_read_data = 32'h0;
    #1;
    checks++; if (o_ls_valid !== 1'b1 || o_ls_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rsp got=%b/%h exp=1/deadbeef", o_ls_valid, o_ls_rdata); end
    step();
    checks++; if (o_ls_valid !== 1'b0) begin failures++; $display("FAIL lw_single_pulse got=%h exp=0", o_ls_valid); end
  endtask

  task automatic test_load_byte();
    ls_drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    i_ram_read_data = 32'h80FF0000;
    #1;
    checks++; if (o_ram_read_req !== 1'b1) begin failures++; $display("FAIL lb_read_req got=%h exp=1", o_ram_read_req); end
    step();
    i_ls_unsigned = 1'b1;
    #1;
    checks++; if (o_ls_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", o_ls_rdata); end
    step();
    i_ls_req = 1'b0;
    #1;
    checks++; if (o_ls_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_unsigned got=%h exp=00000080", o_ls_rdata); end
    step();
  endtask

  task automatic test_store_half();
    ls_drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h102, 32'hABCD1234);
    #1;
    checks++; if (o_ram_byte_enable !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", o_ram_byte_enable); end
    checks++; if (o_ram_write_data !== 32'h12341234) begin failures++; $display("FAIL sh_data got=%h exp=12341234", o_ram_write_data); end
    step();
    i_ls_req = 1'b0;
    #1;
    checks++; if (o_ls_valid !== 1'b1 || o_ls_rdata !== 32'h0) begin failures++; $display("FAIL sh_rsp got=%b/%h exp=1/0", o_ls_valid, o_ls_rdata); end
    step();
  endtask

  task automatic test_misaligned();
    ls_drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    i_ram_read_data = 32'h55555555;
    #1;
    checks++; if (o_ls_ready !== 1'b1 || o_ram_read_req !== 1'b0 || o_ram_write_enable !== 1'b0) begin failures++; $display("FAIL mis_lw_enables got=%b%b%b exp=100", o_ls_ready, o_ram_read_req, o_ram_write_enable); end
    step();
    ls_drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h103, 32'hFFFF);
    #1;
    checks++; if (o_ls_valid !== 1'b1 || o_ls_err !== 1'b1 || o_ls_rdata !== 32'h0) begin failures++; $display("FAIL mis_lw_rsp got=%b/%b/%h exp=1/1/0", o_ls_valid, o_ls_err, o_ls_rdata); end
    checks++; if (o_ram_write_enable !== 1'b0 || o_ram_byte_enable !== 4'b0000) begin failures++; $display("FAIL mis_sh_we got=%b/%b exp=0/0000", o_ram_write_enable, o_ram_byte_enable); end
    step();
    ls_drive(1'b1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (o_ram_read_req !== 1'b0) begin failures++; $display("FAIL mis_size3_read got=%h exp=0", o_ram_read_req); end
    step();
    i_ls_req = 1'b0;
    #1;
    checks++; if (o_ls_err !== 1'b1) begin failures++; $display("FAIL mis_size3_err got=%h exp=1", o_ls_err); end
    step();
    checks++; if (o_ls_err !== 1'b0 || o_ls_valid !== 1'b0) begin failures++; $display("FAIL mis_err_clear got=%b%b exp=00", o_ls_err, o_ls_valid); end
  endtask

  task automatic test_fetch();
    i_if_req = 1'b1; i_if_addr = 32'h206; i_ram_fetch_data = 32'hCAFEF00D;
    #1;
    checks++; if (o_if_ready !== 1'b1 || o_ram_fetch_addr !== 32'h81) begin failures++; $display("FAIL if_accept got=%b/%h exp=1/81", o_if_ready, o_ram_fetch_addr); end
    step();
    i_if_req = 1'b0; i_ram_fetch_data = 32'h0;
    #1;
    checks++; if (o_if_valid !== 1'b1 || o_if_data !== 32'hCAFEF00D) begin failures++; $display("FAIL if_rsp got=%b/%h exp=1/cafef00d", o_if_valid, o_if_data); end
    step();
    checks++; if (o_if_valid !== 1'b0) begin failures++; $display("FAIL if_single_pulse got=%h exp=0", o_if_valid); end
  endtask

  task automatic test_starvation();
    logic [9:0] exp_f;
    exp_f = 10'b1000010000;
    i_if_req = 1'b1; i_if_addr = 32'h200; i_ram_fetch_data = 32'h13;
    ls_drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    i_ram_read_data = 32'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (o_if_ready !== exp_f[i] || o_ls_ready !== ~exp_f[i]) begin
        failures++;
        $display("FAIL starve_grant_%0d got if=%b ls=%b exp if=%b ls=%b", i, o_if_ready, o_ls_ready, exp_f[i], ~exp_f[i]);
      end
      step();
    end
    i_if_req = 1'b0; i_ls_req = 1'b0;
    #1;
    checks++; if (o_if_valid !== 1'b1) begin failures++; $display("FAIL starve_last_if_valid got=%h exp=1", o_if_valid); end
    step();
  endtask

  task automatic test_reset_pending();
    ls_drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    i_ram_read_data = 32'h12345678;
    step();
    i_ls_req = 1'b0;
    #1;
    checks++; if (o_ls_valid !== 1'b1) begin failures++; $display("FAIL rstp_pending got=%h exp=1", o_ls_valid); end
    rst = 1'b0;
    #1;
    checks++; if (o_ls_valid !== 1'b0 || o_ls_rdata !== 32'h0) begin failures++; $display("FAIL rstp_async got=%b/%h exp=0/0", o_ls_valid, o_ls_rdata); end
    step();
    #2 rst = 1'b1;
    i_ls_req = 1'b1;
    #1;
    checks++; if (o_ls_ready !== 1'b1) begin failures++; $display("FAIL rstp_first_accept got=%h exp=1", o_ls_ready); end
    checks++; if (o_ls_valid !== 1'b0) begin failures++; $display("FAIL rstp_no_valid got=%h exp=0", o_ls_valid); end
    step();
    i_ls_req = 1'b0;
    #1;
    checks++; if (o_ls_valid !== 1'b1 || o_ls_rdata !== 32'h12345678) begin failures++; $display("FAIL rstp_rsp got=%b/%h exp=1/12345678", o_ls_valid, o_ls_rdata); end
    step();
  endtask

  task automatic test_clk_en();
    ls_drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    i_ram_read_data = 32'h11223344;
    step();
    clk_en = 1'b0;
    i_if_req = 1'b1;
    i_ram_read_data = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (o_ls_ready !== 1'b0 || o_if_ready !== 1'b0 || o_ram_read_req !== 1'b0 || o_ls_valid !== 1'b1) begin
        failures++;
        $display("FAIL clken_freeze_%0d got rdy=%b%b rd=%b v=%b exp rdy=00 rd=0 v=1", k, o_ls_ready, o_if_ready, o_ram_read_req, o_ls_valid);
      end
      step();
    end
    clk_en = 1'b1; i_ls_req = 1'b0; i_if_req = 1'b0;
    #1;
    checks++; if (o_ls_valid !== 1'b1 || o_ls_rdata !== 32'h11223344) begin failures++; $display("FAIL clken_deliver got=%b/%h exp=1/11223344", o_ls_valid, o_ls_rdata); end
    step();
    checks++; if (o_ls_valid !== 1'b0) begin failures++; $display("FAIL clken_no_repulse got=%h exp=0", o_ls_valid); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; clk_en = 1'b1;
    i_if_req = 1'b0; i_if_addr = '0; i_ram_fetch_data = '0; i_ram_read_data = '0;
    ls_drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_store_load_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_fetch();
    test_starvation();
    test_reset_pending();
    test_clk_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 31, MSB index of byte addresses.
REQ-002 Parameter STARVE_LIMIT, default 4, maximum consecutive LSU grants while fetch is pending.
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 clk_en  in  1  global advance enable; low freezes all state.
REQ-006 i_if_req  in  1  fetch request.
REQ-007 i_if_addr  in  ADDR_WIDTH+1  fetch byte address (word aligned).
REQ-008 o_if_ready  out  1  fetch request accepted this cycle.
REQ-009 o_if_valid / o_if_data  out  1 / 32  fetch response pulse and instruction word.
REQ-010 i_ls_req, i_ls_we  in  1 each  LSU request; 1 = store.
REQ-011 i_ls_size, i_ls_unsigned  in  2 / 1  size 0 byte, 1 half, 2 word; zero-extend loads.
REQ-012 i_ls_addr, i_ls_wdata  in  ADDR_WIDTH+1 / 32  byte address and store data (LSB-justified).
REQ-013 o_ls_ready  out  1  LSU request accepted this cycle.
REQ-014 o_ls_valid, o_ls_rdata, o_ls_err  out  1 / 32 / 1  response pulse, extended load data, misaligned flag.
REQ-015 o_ram_read_req, o_ram_read_addr  out  1 / ADDR_WIDTH+1  RAM data-port read; word index = {2'b0, addr[ADDR_WIDTH:2]}.
REQ-016 i_ram_read_data  in  32  RAM data-port combinational read data.
REQ-017 o_ram_write_enable, o_ram_byte_enable, o_ram_write_addr, o_ram_write_data  out  1 / 4 / ADDR_WIDTH+1 / 32  RAM write port.
REQ-018 o_ram_fetch_addr / i_ram_fetch_data  out / in  ADDR_WIDTH+1 / 32  RAM fetch port (word index).

Function
REQ-019 Handshake: a request is accepted in cycle N iff req && ready && clk_en; its response pulses valid for exactly one clk_en cycle at N+1.
REQ-020 One grant per cycle; back-to-back acceptance permitted every cycle.
REQ-021 Priority: LSU wins when both requesters are pending, except when starve_cnt == STARVE_LIMIT, where fetch wins.
REQ-022 starve_cnt increments on each LSU grant made while i_if_req is high, clears on any fetch grant or when i_if_req is low, and saturates at STARVE_LIMIT.
REQ-023 FSM states: IDLE (no response due), IF_RSP, LS_RSP; the next state is selected by the grant made in the current cycle, or IDLE if there is none.
REQ-024 Misaligned condition: half with addr[0]=1, or word with addr[1:0]!=0; size 3 is treated as misaligned.
REQ-025 Misaligned accept: no RAM access; next cycle o_ls_valid=1, o_ls_err=1, o_ls_rdata=0.
REQ-026 Store accept: o_ram_write_enable=1 in cycle N; byte_enable = 4'b0001/4'b0011/4'b1111 shifted left by addr[1:0]; write_data = byte/half replicated across lanes; o_ls_rdata=0 on response.
REQ-027 Load accept: o_ram_read_req=1 in cycle N; i_ram_read_data is captured at the edge together with addr[1:0], size and unsigned.
REQ-028 Load response: data right-shifted by 8*addr[1:0], then sign- or zero-extended per size and unsigned.
REQ-029 Fetch accept: i_ram_fetch_data is captured; o_if_data is presented in IF_RSP.
REQ-030 Fetch addr[1:0]!=0: the low bits are ignored (word access).
REQ-031 clk_en low: both ready outputs = 0, all RAM enables = 0, registers and pending valid hold; valid is not re-pulsed beyond one enabled cycle.
REQ-032 RAM enables are never asserted without an accepted request.

Reset
REQ-033 rst low asynchronously forces: state IDLE, starve_cnt 0, all valid/err/data outputs 0, RAM enables 0.
REQ-034 A response pending when reset asserts is discarded; the first accept is possible in the first enabled cycle after release.

Structure
REQ-035 Package mem_arb_pkg holds the size enum (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the STARVE_LIMIT default.
REQ-036 Sub-module mem_load_align (combinational shift and extend) is instantiated once.

Verification
REQ-037 Directed scenarios:
- Store word 0xDEADBEEF at 0x100, then load word at 0x100 -> byte_enable 4'b1111, write_addr 0x40; load response 0xDEADBEEF one cycle after accept.
- Load byte signed at 0x103 with RAM word 0x80FF_0000 -> o_ls_rdata 0xFFFFFF80; unsigned -> 0x00000080.
- Store half 0x1234 at 0x102 -> byte_enable 4'b1100, write_data 0x12341234.
- Load word at 0x101 -> no RAM enable; next cycle o_ls_valid=1, o_ls_err=1.
- Both requesters held high for 10 cycles -> grants L,L,L,L,F,L,L,L,L,F.
- rst low while LS_RSP is pending -> outputs 0 immediately, no valid after release; clk_en=0 for 3 cycles mid-stream -> ready 0 and the pending valid delivered on re-enable.
